ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the execute stage (ALU: add/sub/and/or/xor units plus the negative/zero/overflow/carry flag logic) and the memory stage of the 64-bit pipelined ARM CPU. It captures the ALU result, store data and destination/control bits of the instruction in EX, and holds the architectural NZVC condition-flag register, updated only by flag-setting instructions (ADDS/SUBS). It supports stall (hold) and flush (bubble) control from the hazard unit. It also gives the branch logic in EX a flag view that already includes the EX instruction's flags, for CBZ/B.cond resolution.

## Interface
Parameters:
- WIDTH, 64, datapath width of result and store data
- RBITS, 5, register-index width; index 31 is XZR

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ex_valid  in  1  EX holds a real instruction
- ex_result  in  WIDTH  ALU result
- ex_negative, ex_zero, ex_overflow, ex_carry  in  1 each  ALU flags for ex_result
- ex_set_flags  in  1  instruction writes NZVC
- ex_rd  in  RBITS  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_store_data  in  WIDTH  value for STUR
- stall  in  1  hold all registered state this cycle
- flush  in  1  squash the EX instruction into a bubble
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control
- mem_result, mem_store_data  out  WIDTH  registered data
- mem_rd  out  RBITS  registered destination
- flag_n, flag_z, flag_v, flag_c  out  1 each  architectural flag register
- fwd_n, fwd_z, fwd_v, fwd_c  out  1 each  combinational flags for B.cond in EX

## Operation
- Commit condition: `commit = ex_valid & ~stall & ~flush`.
- Priority: reset > flush > stall > normal.
- Normal (commit=1): all mem_* registers load their ex_* counterparts; mem_valid <= 1.
- XZR rule: if ex_rd == 31, mem_reg_write is loaded as 0 regardless of ex_reg_write. mem_rd still loads 31.
- Bubble:
  - Applies when flush=1, or when ex_valid=0 with stall=0.
  - mem_valid, mem_reg_write, mem_mem_read and mem_mem_write load 0.
  - Data/rd registers load ex_* values (don't-care, but must be deterministic).
- Stall=1, flush=0: every register, including the flags, keeps its value.
- Flags update: on commit & ex_set_flags, {flag_n, flag_z, flag_v, flag_c} <= {ex_negative, ex_zero, ex_overflow, ex_carry}. Otherwise the flags hold. Flags never change on a bubble, a stall or a flush.
- Forwarding:
  - fwd_* = ex_* flags when ex_valid & ex_set_flags & ~flush; otherwise fwd_* = flag_*.
  - fwd_* ignores stall, so a stalled ADDS still forwards its own flags.
- Flush and stall asserted together: the flush wins and a bubble is inserted.

## Timing
- Latency 1 cycle: ex_* sampled at edge k appears on mem_* (and flag_*) after edge k.
- fwd_* is purely combinational from the current-cycle inputs and flag_*, with no register in the path.
- Reset: all outputs go to 0 asynchronously, independent of clk. This covers mem_valid, control bits, mem_result, mem_store_data, mem_rd and flag_*. fwd_* then equals the inputs or 0 per the forwarding rule.
- Reset released mid-stream: the first edge after deassertion behaves as a normal edge. No extra bubble cycle.
- Reset asserted between edges while mem_valid=1: outputs clear immediately. The instruction is lost; this is acceptable.
- No handshake beyond stall/flush. The stage always accepts when stall=0.

## Test plan
- Reset: assert reset mid-cycle with mem_valid=1 and flags=1111 -> all outputs 0 before the next edge; release, then send ADD result 0x5, rd=3 -> next edge mem_result=0x5, mem_rd=3, mem_reg_write=1, flags stay 0000.
- SUBS flag update: ex_result=0, N=0, Z=1, V=0, C=1, set_flags=1 -> after the edge flag_nzvc=0101; in the same cycle fwd_nzvc=0101 while flag_nzvc is still the old 0000.
- Stall hold: load result 0xDEAD_BEEF, then stall=1 for 3 cycles with different ex_* and set_flags=1 -> mem_result stays 0xDEAD_BEEF and flags unchanged; stall=0 -> new value loads next edge.
- Flush with stall: ex_valid=1, ex_mem_write=1, ex_set_flags=1, flush=1, stall=1 -> after the edge mem_valid=0, mem_mem_write=0, flags unchanged; fwd_* equals flag_*.
- XZR write: ADDS rd=31, reg_write=1 -> mem_reg_write=0, mem_valid=1, flags updated from ex_*.
- Back-to-back: ADDS (N=1), then an ADD with no set_flags, then a bubble (ex_valid=0) -> flag_n=1 persists through all three edges; mem_valid sequence is 1, 1, 0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bundle: execute-stage outputs and hazard controls in,
// registered memory-stage view, condition flags and forwarded flags out.
interface ex_mem_stage_if #(
    parameter int WIDTH = 64,
    parameter int RBITS = 5
);
    logic             ex_valid;
    logic [WIDTH-1:0] ex_result;
    logic             ex_negative;
    logic             ex_zero;
    logic             ex_overflow;
    logic             ex_carry;
    logic             ex_set_flags;
    logic [RBITS-1:0] ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [WIDTH-1:0] ex_store_data;
    logic             stall;
    logic             flush;

    logic             mem_valid;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic [WIDTH-1:0] mem_result;
    logic [WIDTH-1:0] mem_store_data;
    logic [RBITS-1:0] mem_rd;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic             flag_c;
    logic             fwd_n;
    logic             fwd_z;
    logic             fwd_v;
    logic             fwd_c;

    modport master (
        output ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry,
               ex_set_flags, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_store_data, stall, flush,
        input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_result, mem_store_data, mem_rd,
               flag_n, flag_z, flag_v, flag_c, fwd_n, fwd_z, fwd_v, fwd_c
    );

    modport slave (
        input  ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry,
               ex_set_flags, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_store_data, stall, flush,
        output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_result, mem_store_data, mem_rd,
               flag_n, flag_z, flag_v, flag_c, fwd_n, fwd_z, fwd_v, fwd_c
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZVC flag register and a
// combinational flag view for branch resolution in EX.
module ex_mem_stage #(
    parameter int WIDTH = 64,
    parameter int RBITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    ex_mem_stage_if.slave bus
);
    localparam logic [RBITS-1:0] XZR = RBITS'(31);

    logic             commit;
    logic             load;
    logic             valid_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] store_data_q;
    logic [RBITS-1:0] rd_q;
    logic [3:0]       nzvc_q;
    logic             use_ex_flags;

    assign commit = bus.ex_valid & ~bus.stall & ~bus.flush;
    // Flush overrides stall, so the registers move on either a flush or a non-stalled cycle.
    assign load   = bus.flush | ~bus.stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            nzvc_q       <= 4'b0000;
        end else if (load) begin
            valid_q      <= commit;
            reg_write_q  <= commit & bus.ex_reg_write & (bus.ex_rd != XZR);
            mem_read_q   <= commit & bus.ex_mem_read;
            mem_write_q  <= commit & bus.ex_mem_write;
            result_q     <= bus.ex_result;
            store_data_q <= bus.ex_store_data;
            rd_q         <= bus.ex_rd;
            if (commit & bus.ex_set_flags)
                nzvc_q <= {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry};
        end
    end

    // Stall is deliberately ignored: a held ADDS must still steer its own B.cond.
    assign use_ex_flags = bus.ex_valid & bus.ex_set_flags & ~bus.flush;

    assign bus.mem_valid      = valid_q;
    assign bus.mem_reg_write  = reg_write_q;
    assign bus.mem_mem_read   = mem_read_q;
    assign bus.mem_mem_write  = mem_write_q;
    assign bus.mem_result     = result_q;
    assign bus.mem_store_data = store_data_q;
    assign bus.mem_rd         = rd_q;
    assign {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = nzvc_q;
    assign {bus.fwd_n, bus.fwd_z, bus.fwd_v, bus.fwd_c} = use_ex_flags ?
           {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry} : nzvc_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_ex_mem_stage;
    localparam int WIDTH = 64;
    localparam int RBITS = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.WIDTH(WIDTH), .RBITS(RBITS)) bus ();

    ex_mem_stage #(.WIDTH(WIDTH), .RBITS(RBITS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference state
    logic             m_valid, m_rw, m_mr, m_mw;
    logic [WIDTH-1:0] m_result, m_sd;
    logic [RBITS-1:0] m_rd;
    logic [3:0]       m_flags;

    function automatic logic [3:0] ex_nzvc();
        return {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry};
    endfunction

    function automatic logic [3:0] exp_fwd();
        if (bus.ex_valid && bus.ex_set_flags && !bus.flush) return ex_nzvc();
        return m_flags;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_result = '0; m_sd = '0; m_rd = '0; m_flags = 4'b0000;
    endtask

    // Next state from the priority rules: flush, then stall, then bubble/commit.
    task automatic model_step();
        if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_result = bus.ex_result; m_sd = bus.ex_store_data; m_rd = bus.ex_rd;
        end else if (!bus.stall) begin
            m_valid = 1;
            m_rw = bus.ex_reg_write && (int'(bus.ex_rd) != 31);
            m_mr = bus.ex_mem_read; m_mw = bus.ex_mem_write;
            m_result = bus.ex_result; m_sd = bus.ex_store_data; m_rd = bus.ex_rd;
            if (bus.ex_set_flags) m_flags = ex_nzvc();
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [140:0] obs, exp;
        obs = {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
               bus.mem_result, bus.mem_store_data, bus.mem_rd,
               bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c};
        exp = {m_valid, m_rw, m_mr, m_mw, m_result, m_sd, m_rd, m_flags};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_fwd(input string tag);
        chk(tag, 64'({bus.fwd_n, bus.fwd_z, bus.fwd_v, bus.fwd_c}), 64'(exp_fwd()));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [3:0] nzvc,
                         input logic sf, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic [63:0] sd,
                         input logic st, input logic fl);
        bus.ex_valid = v; bus.ex_result = res;
        {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry} = nzvc;
        bus.ex_set_flags = sf; bus.ex_rd = rd; bus.ex_reg_write = rw;
        bus.ex_mem_read = mr; bus.ex_mem_write = mw; bus.ex_store_data = sd;
        bus.stall = st; bus.flush = fl;
    endtask

    task automatic drive_random();
        logic [4:0] rd;
        rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        drive($urandom_range(0, 4) != 0, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
              $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("reset_initial");
        @(negedge clk);
        reset = 0;

        // Load flags 1111 with a live instruction in MEM, then reset mid-cycle.
        drive(1, 64'h77, 4'b1111, 1, 5'd2, 1, 0, 0, 64'h11, 0, 0);
        tick("adds_1111");
        chk("flags_1111", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'hF);
        drive(1, 64'h99, 4'b0000, 0, 5'd4, 1, 0, 0, 64'h22, 0, 0);
        #2 reset = 1;
        #1;
        model_reset();
        check_all("async_reset_clear");
        check_fwd("fwd_during_reset");
        #1 reset = 0;

        drive(1, 64'h5, 4'b0000, 0, 5'd3, 1, 0, 0, 64'h0, 0, 0);
        tick("add_after_reset");
        chk("post_reset_result", bus.mem_result, 64'h5);
        chk("post_reset_rd", 64'(bus.mem_rd), 64'd3);
        chk("post_reset_rw", 64'(bus.mem_reg_write), 64'd1);
        chk("post_reset_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h0);

        // SUBS: forwarded flags visible before the edge, register after.
        drive(1, 64'h0, 4'b0101, 1, 5'd6, 1, 0, 0, 64'h0, 0, 0);
        #1;
        chk("subs_fwd_early", 64'({bus.fwd_n, bus.fwd_z, bus.fwd_v, bus.fwd_c}), 64'h5);
        chk("subs_flags_old", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h0);
        tick("subs");
        chk("subs_flags_new", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h5);

        // Stall hold for three cycles with changing EX contents.
        drive(1, 64'hDEAD_BEEF, 4'b0000, 0, 5'd7, 1, 0, 0, 64'h0, 0, 0);
        tick("load_deadbeef");
        for (int i = 0; i < 3; i++) begin
            drive(1, {$urandom, $urandom}, 4'b1010, 1, 5'd8, 1, 1, 1, {$urandom, $urandom}, 1, 0);
            #1;
            check_fwd("stall_fwd");
            tick("stall_hold");
            chk("stall_result", bus.mem_result, 64'hDEAD_BEEF);
            chk("stall_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h5);
        end
        drive(1, 64'h1234, 4'b0000, 0, 5'd9, 1, 0, 0, 64'h0, 0, 0);
        tick("stall_release");
        chk("release_result", bus.mem_result, 64'h1234);

        // Flush and stall together.
        drive(1, 64'hABC, 4'b1111, 1, 5'd10, 1, 0, 1, 64'h55, 1, 1);
        #1;
        chk("flush_fwd_is_flags", 64'({bus.fwd_n, bus.fwd_z, bus.fwd_v, bus.fwd_c}), 64'h5);
        tick("flush_stall");
        chk("flush_valid", 64'(bus.mem_valid), 64'd0);
        chk("flush_mw", 64'(bus.mem_mem_write), 64'd0);
        chk("flush_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h5);

        // ADDS to XZR.
        drive(1, 64'hF00, 4'b0011, 1, 5'd31, 1, 0, 0, 64'h0, 0, 0);
        tick("xzr_adds");
        chk("xzr_rw", 64'(bus.mem_reg_write), 64'd0);
        chk("xzr_valid", 64'(bus.mem_valid), 64'd1);
        chk("xzr_rd", 64'(bus.mem_rd), 64'd31);
        chk("xzr_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}), 64'h3);

        // Back-to-back: ADDS N=1, ADD, bubble.
        drive(1, 64'h8000_0000_0000_0000, 4'b1000, 1, 5'd1, 1, 0, 0, 64'h0, 0, 0);
        tick("b2b_adds");
        chk("b2b_n_1", 64'(bus.flag_n), 64'd1);
        chk("b2b_valid_1", 64'(bus.mem_valid), 64'd1);
        drive(1, 64'h42, 4'b0100, 0, 5'd2, 1, 0, 0, 64'h0, 0, 0);
        tick("b2b_add");
        chk("b2b_n_2", 64'(bus.flag_n), 64'd1);
        chk("b2b_valid_2", 64'(bus.mem_valid), 64'd1);
        drive(0, 64'h0, 4'b0100, 1, 5'd3, 1, 1, 1, 64'h0, 0, 0);
        tick("b2b_bubble");
        chk("b2b_n_3", 64'(bus.flag_n), 64'd1);
        chk("b2b_valid_3", 64'(bus.mem_valid), 64'd0);

        // Random traffic with occasional mid-cycle reset.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            #1;
            check_fwd("rand_fwd");
            if ($urandom_range(0, 39) == 0) begin
                reset = 1;
                #1;
                model_reset();
                check_all("rand_reset");
                reset = 0;
            end
            tick("rand_step");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
